// File: rtl/if_prefetch_queue_if.sv
// Bundle of the fetch-side and decode-side signals of the instruction prefetch queue.
//   imem_req / imem_addr / imem_rdata : instruction memory request and one-cycle-late response
//   redirect_valid / redirect_pc      : flush the queue and restart fetch at a new address
//   out_valid / out_ready             : head-entry handshake towards decode
//   out_instr / out_pc4               : head instruction and its fetch address + 4
//   occupancy                         : number of valid queue entries
// The master modport is the queue itself; the slave modport is its environment.
interface if_prefetch_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_pc4;
  logic [CNT_W-1:0]  occupancy;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc4, occupancy,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc4, occupancy,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue between the instruction memory and decode.
// Issues sequential fetches while there is room for the response (queued entries plus the one
// in flight must stay below DEPTH), captures each response one cycle after its request, and
// presents the oldest entry to decode. A redirect flushes the queue and restarts fetch.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : master modport of if_prefetch_queue_if (memory, redirect and decode signals)
module if_prefetch_queue #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               reset,
  if_prefetch_queue_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] issued_pc_q;
  logic              inflight_q;
  logic              kill_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [DATA_W-1:0] pc4_mem   [DEPTH];

  logic has_credit;
  logic issue;
  logic push;
  logic pop;
  logic head_valid;

  // Counting the in-flight response as occupied guarantees a push never finds the queue full.
  assign has_credit = ((CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(DEPTH);
  assign issue      = ~reset & ~bus.redirect_valid & has_credit;
  // A response landing in a redirect cycle belongs to the abandoned path.
  assign push       = inflight_q & ~kill_q & ~bus.redirect_valid;
  assign head_valid = (count_q != '0);
  assign pop        = head_valid & bus.out_ready & ~bus.redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + DATA_W'(4);
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
      kill_q      <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      kill_q     <= bus.redirect_valid;
      if (issue) begin
        issued_pc_q <= fetch_pc_q;
      end
      if (bus.redirect_valid) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          tail_q <= tail_q + PTR_W'(1);
        end
        if (pop) begin
          head_q <= head_q + PTR_W'(1);
        end
        count_q <= count_d;
      end
    end
  end

  // Payload storage needs no reset: entries are only observed through head_valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem[tail_q] <= bus.imem_rdata;
      pc4_mem[tail_q]   <= issued_pc_q + DATA_W'(4);
    end
  end

  // Decode-side outputs are forced quiet while reset is held, even before the first edge clears
  // the pointers.
  always_comb begin
    bus.imem_req  = issue;
    bus.imem_addr = fetch_pc_q;
    bus.out_valid = ~reset & head_valid;
    bus.occupancy = reset ? '0 : count_q;
    bus.out_instr = '0;
    bus.out_pc4   = '0;
    if (!reset && head_valid) begin
      bus.out_instr = instr_mem[head_q];
      bus.out_pc4   = pc4_mem[head_q];
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: directed vector tables, hand-written corner
// sequences and a randomized run, all compared against a queue-based reference model.
module tb_if_prefetch_queue;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RPC2   = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  if_prefetch_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus1 ();
  if_prefetch_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus2 ();

  if_prefetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  if_prefetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RPC2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Reference model: a plain queue of delivered-to-be entries plus one pending fetch.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_addr = 32'h0;
  bit          m_req, m_valid;
  bit          c_rst, c_redir, c_rdy;
  logic [31:0] c_rpc;
  bit          last_req = 1'b0;
  logic [31:0] last_addr = 32'h0;

  task automatic apply(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy);
    c_rst = rst; c_redir = redir; c_rpc = rpc; c_rdy = rdy;
    reset               = rst;
    bus1.redirect_valid = redir;
    bus1.redirect_pc    = rpc;
    bus1.out_ready      = rdy;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    bus2.out_ready      = 1'b1;
    @(negedge clk);
    m_req   = !rst && !redir && ((mq.size() + int'(m_pend)) < int'(DEPTH));
    m_valid = !rst && (mq.size() != 0);
    chk("imem_req", 32'(bus1.imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", bus1.imem_addr, m_pc);
    chk("out_valid", 32'(bus1.out_valid), 32'(m_valid));
    chk("occupancy", 32'(bus1.occupancy), rst ? 32'd0 : 32'(mq.size()));
    if (m_valid) begin
      chk("out_instr", bus1.out_instr, mq[0].instr);
      chk("out_pc4", bus1.out_pc4, mq[0].pc4);
    end else if (rst) begin
      chk("reset_instr", bus1.out_instr, 32'h0);
      chk("reset_pc4", bus1.out_pc4, 32'h0);
    end
  endtask

  task automatic advance();
    logic        r1, r2;
    logic [31:0] a1, a2;
    r1 = bus1.imem_req; a1 = bus1.imem_addr;
    r2 = bus2.imem_req; a2 = bus2.imem_addr;
    @(posedge clk);
    if (c_rst) begin
      mq.delete(); m_pend = 1'b0; m_pc = 32'h0;
    end else if (c_redir) begin
      mq.delete(); m_pend = 1'b0; m_pc = c_rpc;
    end else begin
      if (m_valid && c_rdy) void'(mq.pop_front());
      if (m_pend) mq.push_back('{instr: mem_word(m_pend_addr), pc4: m_pend_addr + 32'd4});
      m_pend = m_req;
      if (m_req) begin
        m_pend_addr = m_pc;
        m_pc        = m_pc + 32'd4;
      end
    end
    last_req  = r1;
    last_addr = a1;
    #1;
    bus1.imem_rdata = r1 ? mem_word(a1) : 32'hDEAD_BEEF;
    bus2.imem_rdata = r2 ? mem_word(a2) : 32'hDEAD_BEEF;
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc4;
    int          occ;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input bit rst, input bit rdy, input bit req,
                              input logic [31:0] addr, input bit valid,
                              input logic [31:0] pc4, input int occ);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.req = req; v.addr = addr;
    v.valid = valid; v.pc4 = pc4; v.occ = occ;
    tv.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit full, fired, bad, reached;

    bus1.imem_rdata = 32'hDEAD_BEEF;
    bus2.imem_rdata = 32'hDEAD_BEEF;

    // Streaming with decode always ready.
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 32'd0,  0, 0, 0);
    add(0, 1, 1, 32'd4,  0, 0, 0);
    add(0, 1, 1, 32'd8,  1, 32'd4,  1);
    add(0, 1, 1, 32'd12, 1, 32'd8,  1);
    add(0, 1, 1, 32'd16, 1, 32'd12, 1);
    add(0, 1, 1, 32'd20, 1, 32'd16, 1);
    // Decode stalled from C0: fill to DEPTH, then drain in order.
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 32'd0,  0, 0, 0);
    add(0, 0, 1, 32'd4,  0, 0, 0);
    add(0, 0, 1, 32'd8,  1, 32'd4, 1);
    add(0, 0, 1, 32'd12, 1, 32'd4, 2);
    add(0, 0, 0, 0,      1, 32'd4, 3);
    add(0, 0, 0, 0,      1, 32'd4, 4);
    add(0, 0, 0, 0,      1, 32'd4, 4);
    add(0, 1, 0, 0,      1, 32'd4, 4);
    add(0, 1, 1, 32'd16, 1, 32'd8, 3);
    add(0, 1, 1, 32'd20, 1, 32'd12, 2);
    add(0, 1, 1, 32'd24, 1, 32'd16, 2);

    foreach (tv[i]) begin
      apply(tv[i].rst, 1'b0, 32'h0, tv[i].rdy);
      chk($sformatf("tv%0d_req", i), 32'(bus1.imem_req), 32'(tv[i].req));
      if (tv[i].req) chk($sformatf("tv%0d_addr", i), bus1.imem_addr, tv[i].addr);
      chk($sformatf("tv%0d_valid", i), 32'(bus1.out_valid), 32'(tv[i].valid));
      if (tv[i].valid) chk($sformatf("tv%0d_pc4", i), bus1.out_pc4, tv[i].pc4);
      chk($sformatf("tv%0d_occ", i), 32'(bus1.occupancy), 32'(tv[i].occ));
      advance();
    end

    // Full queue, then redirect to 0x100: empty next cycle, target visible three cycles later.
    full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0);
      if (bus1.occupancy == 3'd4) begin
        full = 1'b1;
        advance();
        break;
      end
      advance();
    end
    chk("full_reached", 32'(full), 32'd1);
    apply(1'b0, 1'b1, 32'h100, 1'b1);
    chk("redir_req_blocked", 32'(bus1.imem_req), 32'd0);
    advance();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_t1_occ", 32'(bus1.occupancy), 32'd0);
    chk("redir_t1_req", 32'(bus1.imem_req), 32'd1);
    chk("redir_t1_addr", bus1.imem_addr, 32'h100);
    advance();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_t2_valid", 32'(bus1.out_valid), 32'd0);
    advance();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_t3_valid", 32'(bus1.out_valid), 32'd1);
    chk("redir_t3_pc4", bus1.out_pc4, 32'h104);
    chk("redir_t3_instr", bus1.out_instr, mem_word(32'h100));
    advance();

    // Redirect in the very cycle the response for 0x20 returns; that entry must never appear.
    apply(1'b1, 1'b0, 32'h0, 1'b1);
    advance();
    fired = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (last_req && last_addr == 32'h20) begin
        apply(1'b0, 1'b1, 32'h200, 1'b1);
        advance();
        fired = 1'b1;
        break;
      end
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      advance();
    end
    chk("kill_redirect_fired", 32'(fired), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      if (bus1.out_valid && bus1.out_pc4 == 32'h24) bad = 1'b1;
      advance();
    end
    chk("killed_entry_delivered", 32'(bad), 32'd0);

    // Address wrap on the second instance, driven by the shared reset.
    apply(1'b1, 1'b0, 32'h0, 1'b1);
    advance();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      if (k < 3) chk($sformatf("wrap_req%0d", k), 32'(bus2.imem_req), 32'd1);
      if (k == 0) chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFF8);
      if (k == 1) chk("wrap_addr1", bus2.imem_addr, 32'hFFFF_FFFC);
      if (k == 2) begin
        chk("wrap_addr2", bus2.imem_addr, 32'h0000_0000);
        chk("wrap_pc4_first", bus2.out_pc4, 32'hFFFF_FFFC);
      end
      if (k == 3) begin
        chk("wrap_valid_second", 32'(bus2.out_valid), 32'd1);
        chk("wrap_pc4_second", bus2.out_pc4, 32'h0000_0000);
      end
      advance();
    end

    // One-cycle reset with three entries queued.
    apply(1'b1, 1'b0, 32'h0, 1'b0);
    advance();
    reached = 1'b0;
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0);
      if (bus1.occupancy == 3'd3) begin
        reached = 1'b1;
        advance();
        break;
      end
      advance();
    end
    chk("three_queued", 32'(reached), 32'd1);
    apply(1'b1, 1'b0, 32'h0, 1'b0);
    advance();
    apply(1'b0, 1'b0, 32'h0, 1'b0);
    chk("midreset_occ", 32'(bus1.occupancy), 32'd0);
    chk("midreset_valid", 32'(bus1.out_valid), 32'd0);
    chk("midreset_req", 32'(bus1.imem_req), 32'd1);
    chk("midreset_addr", bus1.imem_addr, 32'h0);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(9) < 7);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 Parameter: DATA_W, 32, instruction and PC width in bits.
REQ-002 Parameter: DEPTH, 4, queue entries; power of two, minimum 2.
REQ-003 Parameter: RESET_PC, 0, first fetch address after reset.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: imem_req  out  1  fetch issued this cycle.
REQ-007 Port: imem_addr  out  DATA_W  fetch address; valid when imem_req=1.
REQ-008 Port: imem_rdata  in  DATA_W  instruction word; valid exactly one cycle after its imem_req.
REQ-009 Port: redirect_valid  in  1  flush and restart fetch (jump or taken branch).
REQ-010 Port: redirect_pc  in  DATA_W  restart address; sampled when redirect_valid=1.
REQ-011 Port: out_valid  out  1  head entry available to ID.
REQ-012 Port: out_ready  in  1  ID accepts head; 0 = ID stall.
REQ-013 Port: out_instr  out  DATA_W  head instruction.
REQ-014 Port: out_pc4  out  DATA_W  head fetch address + 4.
REQ-015 Port: occupancy  out  clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-016 The block SHALL hold fetch_pc, a circular queue of {instr, pc4} with head/tail pointers, and a 1-bit in-flight flag with a kill bit.
REQ-017 imem_req SHALL be 1 iff reset=0, redirect_valid=0 and occupancy + in-flight < DEPTH; imem_addr SHALL equal fetch_pc.
REQ-018 On issue, fetch_pc SHALL advance by 4 modulo 2^DATA_W (0xFFFFFFFC wraps to 0x00000000).
REQ-019 A response SHALL be written at the tail on the cycle after issue, with pc4 = issued address + 4, unless killed.
REQ-020 A written entry SHALL become visible on out_* in the following cycle; there is no bypass from imem_rdata to out_*.
REQ-021 out_valid SHALL equal (occupancy != 0); out_instr/out_pc4 SHALL show the head entry.
REQ-022 Pop SHALL occur when out_valid=1, out_ready=1, redirect_valid=0; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-023 The credit rule of REQ-017 SHALL guarantee no push to a full queue; pointers SHALL wrap modulo DEPTH.
REQ-024 redirect_valid=1 in cycle t SHALL: clear the queue at end of t, set fetch_pc to redirect_pc, kill any response returning in t+1, and ignore out_ready in t.
REQ-025 After a redirect in cycle t, the target SHALL be requested in t+1 and appear on out_* in t+3.
REQ-026 A response returning in the same cycle as redirect_valid SHALL be discarded.
REQ-027 With out_ready held at 1 and no redirect, the block SHALL sustain one entry delivered per cycle.

Reset
REQ-028 While reset=1: fetch_pc=RESET_PC, queue empty, in-flight=0, imem_req=0, out_valid=0, occupancy=0, out_instr=0, out_pc4=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries and any in-flight response at the next edge.
REQ-030 In the first cycle C0 with reset=0, imem_req SHALL be 1 with imem_addr=RESET_PC; the first entry SHALL be visible in C2.

Verification
REQ-031 Reset release, out_ready=1, memory returns addr: imem_addr 0,4,8,... from C0; out_valid from C2 with out_pc4 4,8,12,... on consecutive cycles.
REQ-032 out_ready=0 from C0: occupancy reaches 4 (DEPTH=4); imem_req=0 thereafter; head stays instr@0; out_ready=1 then drains 0,4,8,12 in order.
REQ-033 Queue full, redirect_valid=1 with redirect_pc=0x100: occupancy=0 next cycle; next delivered out_pc4=0x104, three cycles after the redirect.
REQ-034 Redirect in the cycle a response for 0x20 returns: no entry with out_pc4=0x24 is ever delivered.
REQ-035 RESET_PC=0xFFFFFFF8: fetch addresses FFFFFFF8, FFFFFFFC, 00000000; out_pc4 of the second entry = 0x00000000.
REQ-036 Reset asserted for one cycle with 3 entries queued: out_valid=0 and occupancy=0 next cycle; fetch restarts at RESET_PC.
